// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between a datapath and mem_responder
interface mem_responder_if;
  logic req;
  logic we;
  logic [31:0] Adr;
  logic [3:0] byteEnable;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic ready;
  logic busy;
  logic err;
  modport master (output req, we, Adr, byteEnable, WriteData, input ReadData, ready, busy, err);
  modport slave (input req, we, Adr, byteEnable, WriteData, output ReadData, ready, busy, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word memory slave with fixed wait states, byte-lane writes and an out-of-range flag
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  mem_responder_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx, c_be, a_be;
  logic [29:0] c_idx, a_idx;
  logic [31:0] c_wd, a_wd, rdata;
  logic c_we, a_we, accept, a_oor, commit;
  logic [31:0] mem [DEPTH_WORDS];
  // In IDLE the access comes straight off the bus, so a zero-wait access commits on its accepting edge
  always_comb begin
    accept = state == IDLE && bus.req;
    a_we = accept ? bus.we : c_we;
    a_idx = accept ? bus.Adr[31:2] : c_idx;
    a_be = accept ? bus.byteEnable : c_be;
    a_wd = accept ? bus.WriteData : c_wd;
    a_oor = a_idx >= 30'(DEPTH_WORDS);
    state_nx = state == IDLE ? (bus.req ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
             : IDLE;
    cnt_nx = accept ? 4'(WAIT_CYCLES) : state == WAIT ? cnt - 4'd1 : cnt;
    commit = state_nx == RESP;
    bus.ready = state == RESP;
    bus.busy = state != IDLE;
    bus.err = state == RESP && c_idx >= 30'(DEPTH_WORDS);
    bus.ReadData = rdata;
  end
  // Storage sits outside the reset branch: reset aborts a pending commit but never clears contents
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      c_we <= 1'b0;
      c_idx <= '0;
      c_be <= '0;
      c_wd <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        c_we <= bus.we;
        c_idx <= bus.Adr[31:2];
        c_be <= bus.byteEnable;
        c_wd <= bus.WriteData;
      end
      if (commit && !a_we) rdata <= a_oor ? '0 : mem[a_idx[AW-1:0]];
      if (commit && a_we && !a_oor)
        for (int i = 0; i < 4; i++)
          if (a_be[i]) mem[a_idx[AW-1:0]][8*i +: 8] <= a_wd[8*i +: 8];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for a 2-wait-state and a 0-wait-state mem_responder
module tb_mem_responder;
  logic clk, reset;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  mem_responder_if b2 ();
  mem_responder_if b0 ();
  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(b2.slave));
  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic err;
    int acc;
  } exp_t;
  exp_t q [2][$];
  // Reference model: per-bit "known" masks because storage is undefined until written
  bit [31:0] mmem [2][64];
  bit [31:0] mknown [2][64];
  bit [31:0] mlast [2];
  bit [31:0] mlastk [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic predict(input int d, input bit we, input logic [31:0] adr, input logic [3:0] be,
                         input logic [31:0] wd, input bit apply, output exp_t e);
    longint w = longint'(adr >> 2);
    bit oor = w >= 64;
    e.acc = cyc;
    e.err = oor;
    if (we) begin
      e.data = mlast[d];
      e.mask = mlastk[d];
      if (apply && !oor)
        for (int i = 0; i < 4; i++)
          if (be[i]) begin
            mmem[d][int'(w)][8*i +: 8] = wd[8*i +: 8];
            mknown[d][int'(w)][8*i +: 8] = 8'hFF;
          end
    end else begin
      e.data = 32'h0;
      e.mask = 32'hFFFF_FFFF;
      if (!oor) begin
        e.data = mmem[d][int'(w)];
        e.mask = mknown[d][int'(w)];
      end
      if (apply) begin
        mlast[d] = e.data;
        mlastk[d] = e.mask;
      end
    end
  endtask

  always @(negedge clk) begin
    logic r, b, er;
    logic [31:0] rd;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      r = d == 0 ? b2.ready : b0.ready;
      b = d == 0 ? b2.busy : b0.busy;
      er = d == 0 ? b2.err : b0.err;
      rd = d == 0 ? b2.ReadData : b0.ReadData;
      chk(b === (q[d].size() != 0), $sformatf("busy%0d", d), 32'(b), 32'(q[d].size() != 0));
      if (r === 1'b1) begin
        if (q[d].size() == 0) chk(1'b0, $sformatf("unexpected_ready%0d", d), 32'(r), 32'h0);
        else begin
          e = q[d].pop_front();
          chk(cyc - e.acc + 1 == (d == 0 ? 3 : 1), $sformatf("latency%0d", d), 32'(cyc - e.acc + 1), d == 0 ? 32'd3 : 32'd1);
          chk(er === e.err, $sformatf("err%0d", d), 32'(er), 32'(e.err));
          chk(((rd ^ e.data) & e.mask) === 32'h0, $sformatf("rdata%0d", d), rd, e.data);
        end
      end else chk(er === 1'b0, $sformatf("err_idle%0d", d), 32'(er), 32'h0);
    end
  end

  task automatic access(input bit we, input logic [31:0] adr, input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    int n = 0;
    b2.req = 1'b1;
    b2.we = we;
    b2.Adr = adr;
    b2.byteEnable = be;
    b2.WriteData = wd;
    @(posedge clk);
    #1;
    predict(0, we, adr, be, wd, 1'b1, e);
    q[0].push_back(e);
    do begin
      @(negedge clk);
      n++;
      if (b2.ready !== 1'b1) begin
        b2.we = 1'($urandom_range(0, 1));
        b2.Adr = $urandom;
        b2.byteEnable = 4'($urandom_range(0, 15));
        b2.WriteData = $urandom;
      end
    end while (b2.ready !== 1'b1 && n < 40);
    if (b2.ready !== 1'b1) chk(1'b0, "ready_timeout", 32'(b2.ready), 32'h1);
    b2.req = 1'b0;
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  // Zero-wait port: req stays high, so a new op is accepted every second edge
  task automatic access0(input bit we, input logic [31:0] adr, input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    b0.req = 1'b1;
    b0.we = we;
    b0.Adr = adr;
    b0.byteEnable = be;
    b0.WriteData = wd;
    @(posedge clk);
    #1;
    predict(1, we, adr, be, wd, 1'b1, e);
    q[1].push_back(e);
    @(negedge clk);
    b0.we = 1'($urandom_range(0, 1));
    b0.Adr = $urandom;
    b0.byteEnable = 4'($urandom_range(0, 15));
    b0.WriteData = $urandom;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [29:0] w;
    logic [31:0] adr;
    for (int d = 0; d < 2; d++) begin
      mlast[d] = 32'h0;
      mlastk[d] = 32'hFFFF_FFFF;
    end
    reset = 1'b1;
    {b2.req, b2.we, b2.Adr, b2.byteEnable, b2.WriteData} = '0;
    {b0.req, b0.we, b0.Adr, b0.byteEnable, b0.WriteData} = '0;
    #3;
    chk({b2.ready, b2.busy, b2.err} === 3'b000, "reset_flags", 32'({b2.ready, b2.busy, b2.err}), 32'h0);
    chk(b2.ReadData === 32'h0, "reset_rdata", b2.ReadData, 32'h0);
    chk({b0.ready, b0.busy, b0.err} === 3'b000, "reset_flags0", 32'({b0.ready, b0.busy, b0.err}), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    access(1'b1, 32'h0, 4'hF, 32'h1111_1111);
    access(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    access(1'b0, 32'h10, 4'hF, 32'h0);
    chk(b2.ReadData === 32'hDEAD_BEEF, "full_word_read", b2.ReadData, 32'hDEAD_BEEF);
    access(1'b1, 32'h12, 4'b0100, 32'h00AA_0000);
    access(1'b0, 32'h10, 4'hF, 32'h0);
    chk(b2.ReadData === 32'hDEAA_BEEF, "byte_lane_read", b2.ReadData, 32'hDEAA_BEEF);
    access(1'b1, 32'h100, 4'hF, 32'hCAFE_F00D);
    access(1'b0, 32'h100, 4'hF, 32'h0);
    chk(b2.ReadData === 32'h0, "oor_read_zero", b2.ReadData, 32'h0);
    access(1'b1, 32'h4000_0000, 4'hF, 32'h5555_5555);
    access(1'b0, 32'h0, 4'hF, 32'h0);
    chk(b2.ReadData === 32'h1111_1111, "word0_intact", b2.ReadData, 32'h1111_1111);
    access(1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF);
    access(1'b0, 32'h10, 4'hF, 32'h0);
    access(1'b1, 32'hFC, 4'hF, 32'hA5A5_A5A5);
    access(1'b0, 32'hFF, 4'hF, 32'h0);
    chk(b2.ReadData === 32'hA5A5_A5A5, "last_word", b2.ReadData, 32'hA5A5_A5A5);
    access(1'b1, 32'h20, 4'hF, 32'h0);
    b2.req = 1'b1;
    b2.we = 1'b1;
    b2.Adr = 32'h20;
    b2.byteEnable = 4'hF;
    b2.WriteData = 32'h1234_5678;
    @(posedge clk);
    #1;
    predict(0, 1'b1, 32'h20, 4'hF, 32'h1234_5678, 1'b0, e);
    q[0].push_back(e);
    @(negedge clk);
    #2;
    reset = 1'b1;
    void'(q[0].pop_back());
    #1;
    chk({b2.ready, b2.busy, b2.err} === 3'b000, "abort_flags", 32'({b2.ready, b2.busy, b2.err}), 32'h0);
    chk(b2.ReadData === 32'h0, "abort_rdata", b2.ReadData, 32'h0);
    b2.req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mlast[d] = 32'h0;
      mlastk[d] = 32'hFFFF_FFFF;
    end
    access(1'b0, 32'h20, 4'hF, 32'h0);
    chk(b2.ReadData === 32'h0, "aborted_write_dropped", b2.ReadData, 32'h0);
    repeat (40) begin
      w = 30'($urandom_range(0, 69));
      adr = $urandom_range(0, 7) == 0 ? $urandom : {w, 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), $urandom);
    end
    for (int k = 1; k <= 4; k++) access0(1'b1, 32'(k * 4), 4'hF, $urandom);
    repeat (10) begin
      w = 30'($urandom_range(0, 66));
      access0(1'($urandom_range(0, 3) == 0), {w, 2'b00}, 4'($urandom_range(0, 15)), $urandom);
    end
    b0.req = 1'b0;
    repeat (4) @(negedge clk);
    chk(q[0].size() == 0, "drain0", 32'(q[0].size()), 32'h0);
    chk(q[1].size() == 0, "drain1", 32'(q[1].size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted between accept and response, legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1 bit: access request from the datapath.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port Adr, input, 32 bits: byte address; Adr[31:2] selects the word and Adr[1:0] is ignored.
REQ-008 SHALL have port byteEnable, input, 4 bits: lane enables; bit n covers WriteData[8n+7:8n].
REQ-009 SHALL have port WriteData, input, 32 bits: lane-aligned store data.
REQ-010 SHALL have port ReadData, output, 32 bits: full word read; the datapath does lane extraction.
REQ-011 SHALL have port ready, output, 1 bit: one-cycle completion strobe.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port err, output, 1 bit: out-of-range flag, valid only while ready=1.

Function
REQ-014 SHALL implement the states IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, SHALL capture we, Adr[31:2], byteEnable and WriteData and load the wait counter with WAIT_CYCLES.
- Next state is WAIT when WAIT_CYCLES>0, else RESP.
REQ-016 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where the counter goes from 1 to 0.
REQ-017 In RESP, SHALL drive ready=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-018 Latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to the cycle in which ready=1.
REQ-019 SHALL ignore req, we, Adr, byteEnable and WriteData outside IDLE; the captured copies are used throughout.
REQ-020 SHALL treat req=1 in IDLE, including the cycle right after RESP, as a new request.
- The requestor deasserts req in the cycle it observes ready.
- Minimum back-to-back spacing is therefore WAIT_CYCLES+2 cycles.
REQ-021 Writes SHALL commit on the edge entering RESP.
- Only lanes with the captured byteEnable bit set are updated; other lanes keep their value.
- byteEnable=0000 completes normally with no change.
REQ-022 Reads SHALL load ReadData on the edge entering RESP.
- ReadData holds that value until the next read response or reset; writes do not change ReadData.
REQ-023 Read data SHALL reflect all writes completed before the read was accepted.
REQ-024 An access is out of range when captured Adr[31:2] >= DEPTH_WORDS.
- ready is asserted as normal with err=1.
- No storage is modified.
- For a read, ReadData loads 0.
REQ-025 err SHALL be 0 whenever ready=0.
REQ-026 Captured address arithmetic SHALL use the full 30-bit word index with no wrap-around; index DEPTH_WORDS is out of range, not word 0.

Reset
REQ-027 While reset=1, SHALL hold state IDLE, counter 0, ready=0, busy=0, err=0 and ReadData=0, independent of clk.
REQ-028 Reset asserted mid-access SHALL abort the access.
- An uncommitted write is discarded.
- No ready pulse is issued for the aborted access.
REQ-029 Storage contents SHALL NOT be cleared by reset; contents are undefined until written.
REQ-030 The first edge after reset deasserts SHALL be able to accept a request.

Verification
REQ-031 Full-word write then read, WAIT_CYCLES=2:
- Stimulus: write 0xDEADBEEF at Adr 0x10 with byteEnable=1111, then read Adr 0x10.
- Response: each ready arrives 3 cycles after accept; ReadData=0xDEADBEEF and err=0.
REQ-032 Byte-lane write:
- Stimulus: after REQ-031, write WriteData=0x00AA0000 with byteEnable=0100 at Adr 0x12, then read Adr 0x10.
- Response: ReadData=0xDEAABEEF.
REQ-033 Out-of-range access, DEPTH_WORDS=64:
- Stimulus: write to Adr 0x100, then read Adr 0x100.
- Response: both accesses give ready=1 and err=1; the read returns ReadData=0; word 0 is unchanged.
REQ-034 Zero wait states, WAIT_CYCLES=0:
- Stimulus: back-to-back reads with req held high.
- Response: ready every second cycle; busy=1 only in RESP cycles.
REQ-035 Reset mid-access:
- Stimulus: write 0x12345678 to Adr 0x20 and assert reset during WAIT; release reset and read Adr 0x20.
- Response: no ready for the aborted write; busy=0 immediately on reset; the read does not return 0x12345678 if 0x20 previously held 0x0.
REQ-036 Inputs ignored while busy:
- Stimulus: change Adr, WriteData and byteEnable during WAIT.
- Response: the write lands at the captured address with the captured data.
